// File: rtl/grf_wb_arbiter.sv
// Two-requester writeback arbiter for the single GRF write port; $0 writes are absorbed.
// Build with GRF_WB_RR_EN for round-robin conflict resolution, otherwise req0 has fixed priority.
module grf_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic [DW-1:0] req0_pc,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    input  logic [DW-1:0] req1_pc,
    output logic          grf_we,
    output logic [AW-1:0] grf_a3,
    output logic [DW-1:0] grf_wd,
    output logic [DW-1:0] grf_pc,
    output logic          last_grant,
    output logic [CW-1:0] conflict_cnt
);

    // Handshake: a requester's write is taken in any cycle where valid && ready;
    // ready never depends on grf_*, and a losing requester must hold its fields stable.
    logic          w_real0;
    logic          w_real1;
    logic          w_zero0;
    logic          w_zero1;
    logic          w_conflict;
    logic          w_conflict_pick1;
    logic          w_pick1;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_grant;
    logic          w_cnt_sat;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;
    logic [DW-1:0] w_sel_pc;

    logic          r_we;
    logic [AW-1:0] r_a3;
    logic [DW-1:0] r_wd;
    logic [DW-1:0] r_pc;
    logic          r_last_grant;
    logic [CW-1:0] r_conflict_cnt;

    assign w_real0    = req0_valid && (req0_addr != '0);
    assign w_real1    = req1_valid && (req1_addr != '0);
    assign w_zero0    = req0_valid && (req0_addr == '0);
    assign w_zero1    = req1_valid && (req1_addr == '0);
    assign w_conflict = w_real0 && w_real1;

`ifdef GRF_WB_RR_EN
    assign w_conflict_pick1 = ~r_last_grant;
`else
    assign w_conflict_pick1 = 1'b0;
`endif

    // Outside a conflict, requester 1 is picked exactly when it alone has a real write.
    assign w_pick1  = w_conflict ? w_conflict_pick1 : w_real1;
    assign w_grant0 = w_real0 && !w_pick1;
    assign w_grant1 = w_real1 && w_pick1;
    assign w_grant  = w_grant0 || w_grant1;

    assign req0_ready = !reset && (w_zero0 || w_grant0);
    assign req1_ready = !reset && (w_zero1 || w_grant1);

    assign w_sel_addr = w_pick1 ? req1_addr : req0_addr;
    assign w_sel_data = w_pick1 ? req1_data : req0_data;
    assign w_sel_pc   = w_pick1 ? req1_pc   : req0_pc;

    assign w_cnt_sat = &r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we           <= 1'b0;
            r_a3           <= '0;
            r_wd           <= '0;
            r_pc           <= '0;
            r_last_grant   <= 1'b1;
            r_conflict_cnt <= '0;
        end else begin
            r_we <= w_grant;
            // Address/data/pc hold across idle cycles; only the enable drops.
            if (w_grant) begin
                r_a3         <= w_sel_addr;
                r_wd         <= w_sel_data;
                r_pc         <= w_sel_pc;
                r_last_grant <= w_pick1;
            end
            if (w_conflict && !w_cnt_sat) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign grf_we       = r_we;
    assign grf_a3       = r_a3;
    assign grf_wd       = r_wd;
    assign grf_pc       = r_pc;
    assign last_grant   = r_last_grant;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a queue-based reference model.
module tb_grf_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

`ifdef GRF_WB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic [DW-1:0] req0_pc = '0, req1_pc = '0;
    logic          grf_we;
    logic [AW-1:0] grf_a3;
    logic [DW-1:0] grf_wd;
    logic [DW-1:0] grf_pc;
    logic          last_grant;
    logic [CW-1:0] conflict_cnt;

    grf_wb_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_pc(req0_pc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_pc(req1_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .last_grant(last_grant), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] p;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           m_held = '0;
    logic          m_lg = 1'b1;
    logic [CW-1:0] m_cnt = '0;
    bit            m_sync = 1'b0;
    bit            p_grant = 1'b0, p_win = 1'b0, p_conf = 1'b0;
    wr_t           p_wr = '0;

    // Negedge: decide who must be accepted this cycle and check every output.
    always @(negedge clk) begin
        bit r0, r1, z0, z1, win, e0, e1;
        wr_t cur;
        if (m_sync) begin
            r0 = req0_valid && (req0_addr != 0);
            r1 = req1_valid && (req1_addr != 0);
            z0 = req0_valid && (req0_addr == 0);
            z1 = req1_valid && (req1_addr == 0);
            if (reset) begin
                e0 = 0; e1 = 0; p_grant = 0; p_conf = 0;
            end else begin
                if (r0 && r1) win = RR ? !m_lg : 1'b0;
                else          win = r1;
                e0 = z0 || (r0 && !win);
                e1 = z1 || (r1 && win);
                p_grant = r0 || r1;
                p_win   = win;
                p_conf  = r0 && r1;
                p_wr    = win ? {req1_addr, req1_data, req1_pc} : {req0_addr, req0_data, req0_pc};
            end
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                m_held = cur;
                chk("grf_we", grf_we, 1);
            end else begin
                chk("grf_we", grf_we, 0);
            end
            chk("grf_a3", grf_a3, m_held.a);
            chk("grf_wd", grf_wd, m_held.d);
            chk("grf_pc", grf_pc, m_held.p);
            chk("last_grant", last_grant, m_lg);
            chk("conflict_cnt", conflict_cnt, m_cnt);
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_held = '0;
            m_lg   = 1'b1;
            m_cnt  = '0;
            m_sync = 1'b1;
        end else if (m_sync) begin
            if (p_grant) begin
                exp_q.push_back(p_wr);
                m_lg = p_win;
            end
            if (p_conf && m_cnt != {CW{1'b1}}) m_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] p);
        req0_valid = v; req0_addr = a; req0_data = d; req0_pc = p;
    endtask

    task automatic set1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] p);
        req1_valid = v; req1_addr = a; req1_data = d; req1_pc = p;
    endtask

    task automatic new0();
        set0(1'b1, AW'($urandom_range(1, 31)), $urandom, $urandom);
    endtask

    task automatic new1();
        set1(1'b1, AW'($urandom_range(1, 31)), $urandom, $urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Both requesters stay busy for n cycles; the accepted one gets a fresh write,
    // and on the last cycle it is dropped so only the loser is left to drain.
    task automatic contend(input int n, input bit check_order);
        bit a0;
        new0();
        new1();
        for (int i = 0; i < n; i++) begin
            #1;
            a0 = req0_ready;
            if (check_order) begin
                chk("order_ready0", req0_ready, RR ? ((i % 2) == 0) : 1'b1);
                chk("order_ready1", req1_ready, RR ? ((i % 2) == 1) : 1'b0);
            end
            tick();
            if (i == n - 1) begin
                if (a0) set0(0, 0, 0, 0); else set1(0, 0, 0, 0);
            end else begin
                if (a0) new0(); else new1();
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit a0, a1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // $0 write is acknowledged but never reaches the port
        set1(1, 0, 'hFFFF, 'h10);
        #1 chk("zero_ready1", req1_ready, 1);
        tick();
        set1(0, 0, 0, 0);
        #1 chk("zero_we", grf_we, 0);
        chk("zero_lg", last_grant, 1);

        // single write, one-cycle latency
        set0(1, 5, 'h1234, 'h3000);
        #1 chk("single_ready0", req0_ready, 1);
        tick();
        set0(0, 0, 0, 0);
        #1 chk("single_we", grf_we, 1);
        chk("single_a3", grf_a3, 5);
        chk("single_wd", grf_wd, 'h1234);
        chk("single_pc", grf_pc, 'h3000);
        chk("single_lg", last_grant, 0);
        tick();
        #1 chk("single_we_drop", grf_we, 0);
        chk("single_a3_hold", grf_a3, 5);

        // conflict right after reset: req0 wins in both builds
        do_reset();
        set0(1, 3, 'hA, 'h100);
        set1(1, 4, 'hB, 'h104);
        #1 chk("conf_ready0", req0_ready, 1);
        chk("conf_ready1", req1_ready, 0);
        tick();
        set0(0, 0, 0, 0);
        #1 chk("conf_ready1_next", req1_ready, 1);
        chk("conf_a3_first", grf_a3, 3);
        chk("conf_wd_first", grf_wd, 'hA);
        chk("conf_cnt", conflict_cnt, 1);
        tick();
        set1(0, 0, 0, 0);
        #1 chk("conf_we_second", grf_we, 1);
        chk("conf_a3_second", grf_a3, 4);
        chk("conf_wd_second", grf_wd, 'hB);
        tick();

        // same address on both sides: two writes, later grant last
        set0(1, 9, 'h90, 'h0);
        set1(1, 9, 'h91, 'h4);
        #1 a0 = req0_ready;
        tick();
        if (a0) set0(0, 0, 0, 0); else set1(0, 0, 0, 0);
        #1 chk("same_we_first", grf_we, 1);
        tick();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        #1 chk("same_we_second", grf_we, 1);
        chk("same_wd_second", grf_wd, a0 ? 'h91 : 'h90);
        tick();

        // starvation: six cycles of continuous contention
        do_reset();
        contend(6, 1'b1);
        #1 chk("starve_cnt", conflict_cnt, 6);
        tick();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        tick();

        // saturation: 2^CW+3 conflict cycles
        do_reset();
        contend((1 << CW) + 3, 1'b0);
        tick();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        #1 chk("sat_cnt", conflict_cnt, {CW{1'b1}});

        // reset right after a grant discards it
        set0(1, 7, 'h77, 'h700);
        #1 chk("rst_ready0_pre", req0_ready, 1);
        tick();
        set0(1, 9, 'h99, 'h900);
        set1(1, 0, 'h55, 'h500);
        reset = 1'b1;
        #1 chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1_zero", req1_ready, 0);
        tick();
        #1 chk("rst_we", grf_we, 0);
        chk("rst_a3", grf_a3, 0);
        chk("rst_wd", grf_wd, 0);
        chk("rst_pc", grf_pc, 0);
        chk("rst_lg", last_grant, 1);
        chk("rst_cnt", conflict_cnt, 0);
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        reset = 1'b0;
        tick();
        #1 chk("rst_we_after", grf_we, 0);

        // random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            #1;
            a0 = req0_ready;
            a1 = req1_ready;
            tick();
            reset = ($urandom_range(0, 99) == 0);
            if (!req0_valid || a0) begin
                if ($urandom_range(0, 3) == 0) set0(0, 0, 0, 0);
                else set0(1, AW'($urandom_range(0, 7)), $urandom, $urandom);
            end
            if (!req1_valid || a1) begin
                if ($urandom_range(0, 3) == 0) set1(0, 0, 0, 0);
                else set1(1, AW'($urandom_range(0, 7)), $urandom, $urandom);
            end
        end

        reset = 1'b0;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        tick();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
